xcorr_peak_finder: RTL and testbench
====================================

# xcorr_peak_finder

Reads back the cross-correlation buffer after the correlator finishes and finds its peak. It scans every output address, tracks the running maximum, and reports the winning index, the signed inter-microphone lag and the peak magnitude. It sits on the correlator's output RAM read port, downstream of the correlator's `valid` flag, and feeds the beam-steering delay logic.

## Interface
- `DATA_WIDTH`, 8: width of one correlation sample (unsigned).
- `OUT_ADDR_WIDTH`, 8: correlation buffer address width; N = 2^OUT_ADDR_WIDTH entries.
- `clk` input 1: system clock. One clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `valid_in` input 1: correlator done flag (level); a rising edge starts a search.
- `r_addr` output OUT_ADDR_WIDTH: correlation RAM read address.
- `r_data` input DATA_WIDTH: RAM read data; 1-cycle registered read latency.
- `busy` output 1: high while a search is in progress.
- `done` output 1: one-cycle pulse when results update.
- `peak_idx` output OUT_ADDR_WIDTH: address of the maximum.
- `peak_lag` output OUT_ADDR_WIDTH+1, signed: 2*peak_idx − N.
- `peak_val` output DATA_WIDTH: maximum sample value.
- `thresh` input DATA_WIDTH: present only with PEAK_THRESHOLD_EN.
- `peak_found` output 1: present only with PEAK_THRESHOLD_EN.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Edge detect: `prev_valid` register; start = valid_in & ~prev_valid, sampled in IDLE only. `prev_valid` resets to 1, so a level already high at reset release does not trigger.
- IDLE → SCAN on start. The address counter clears to 0 and the running max clears (max=0, idx=0).
- SCAN: r_addr = counter, counter increments each cycle. Data for address k arrives while address k+1 is driven. Compare runs only when the one-cycle-delayed read-valid flag is set.
- SCAN → DRAIN after address N−1 is issued. DRAIN compares the last sample. DRAIN → DONE.
- DONE: load the output registers from the running max, pulse `done`, then go to IDLE unconditionally.
- Update rule: strict greater-than, so ties resolve to the lowest address. An all-zero buffer gives idx=0 and val=0.
- peak_lag = {1'b0, idx, 1'b0} − N, computed in OUT_ADDR_WIDTH+2 bits and truncated to OUT_ADDR_WIDTH+1 signed. The range is −N … N−2.
- Rising edges of valid_in during SCAN, DRAIN or DONE are ignored. They are not queued.
- The outputs hold their last result until the next DONE.

## Timing
- Reset values: r_addr=0, busy=0, done=0, peak_idx=0, peak_lag=0, peak_val=0, peak_found=0, state IDLE.
- peak_lag is reset to 0, not to −N.
- If the start edge is sampled at edge T:
  - SCAN runs cycles T+1 … T+N, issuing addresses 0 … N−1.
  - DRAIN is cycle T+N+1.
  - DONE is cycle T+N+2, with done=1 and outputs valid in that cycle.
- Total latency is N+2 cycles from the start edge to the done pulse.
- busy is high from T+1 through T+N+2 inclusive.
- The earliest next start is sampled at T+N+3, and only if a fresh rising edge occurs.
- Reset mid-search aborts immediately and returns every output to its reset value. No done pulse is generated.
- Address wrap: the counter is OUT_ADDR_WIDTH+1 bits wide. The terminal test is counter == N−1 on issue, so no wrap to 0 occurs.

## Configuration
- `PEAK_THRESHOLD_EN` defined:
  - Adds the `thresh` input and the `peak_found` output.
  - In DONE, peak_found is registered as (max ≥ thresh).
  - peak_found holds until the next DONE.
  - peak_idx, peak_val and peak_lag update regardless of peak_found.
- `PEAK_THRESHOLD_EN` undefined: both ports are absent and no compare logic is built.

## Structure
- Package `xcorr_pkg` holds:
  - the state enum `peak_state_t`;
  - a localparam function giving N from OUT_ADDR_WIDTH;
  - the lag-width constant.
- Sub-module `peak_tracker` holds the running-max register pair (val, idx). Ports: clear, sample-valid, data, index, max_val, max_idx. Update is strict greater-than.

## Test plan
- Ramp buffer (mem[k]=k, W=8) with a valid_in edge: done at T+258, peak_idx=255, peak_val=255, peak_lag=254.
- Single spike mem[128]=200, rest 10: peak_idx=128, peak_lag=0, peak_val=200. busy is high for exactly 258 cycles.
- Tie case mem[40]=mem[90]=77, rest 0: peak_idx=40, peak_lag=−176.
- valid_in already high at reset release: no search. A later low→high edge gives exactly one search. A second edge mid-scan produces no extra done.
- Reset asserted at scan address 100: outputs return to 0 the next cycle, and no done pulse follows.
- With PEAK_THRESHOLD_EN and thresh=150:
  - spike of 149: peak_found=0, peak_val=149;
  - spike of 150: peak_found=1.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared types and sizing helpers for the cross-correlation peak finder.
package xcorr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } peak_state_t;

    // Number of correlation buffer entries for a given address width.
    function automatic int num_entries(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Lag is one bit wider than the address so it can hold -N ... N-2.
    localparam int LAG_EXTRA_BITS = 1;

    function automatic int lag_width(input int addr_w);
        return addr_w + LAG_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/xcorr_peak_finder_peak_tracker.sv
// Running-maximum register pair (value, index) for the peak finder.
// max_val/max_idx present the maximum including the sample currently on
// the data input, so the caller can capture the final result in the same
// cycle the last sample arrives. Strict greater-than keeps the lowest
// index on ties.
module peak_tracker #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  sample_vld,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [IDX_WIDTH-1:0]  index,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [IDX_WIDTH-1:0]  max_idx
);

    logic [DATA_WIDTH-1:0] val_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic                  take;

    // Merge the stored maximum with the incoming sample.
    always_comb begin
        take    = sample_vld && (data > val_q);
        max_val = take ? data  : val_q;
        max_idx = take ? index : idx_q;
    end

    // Hold the running maximum; cleared at the start of every search.
    always_ff @(posedge clk) begin
        if (clear) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= max_val;
            idx_q <= max_idx;
        end
    end

endmodule

// File: rtl/xcorr_peak_finder.sv
// Cross-correlation peak finder: on a rising edge of valid_in, reads the
// whole correlation buffer (1-cycle RAM latency), tracks the maximum and
// reports its index, signed lag (2*idx - N) and value.
// Optional feature macro: PEAK_THRESHOLD_EN adds thresh / peak_found.
module xcorr_peak_finder
    import xcorr_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_ADDR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_in,
    output logic [OUT_ADDR_WIDTH-1:0]   r_addr,
    input  logic [DATA_WIDTH-1:0]       r_data,
`ifdef PEAK_THRESHOLD_EN
    input  logic [DATA_WIDTH-1:0]       thresh,
    output logic                        peak_found,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [OUT_ADDR_WIDTH-1:0]   peak_idx,
    output logic signed [OUT_ADDR_WIDTH:0] peak_lag,
    output logic [DATA_WIDTH-1:0]       peak_val
);

    localparam int N     = num_entries(OUT_ADDR_WIDTH);
    localparam int LAG_W = lag_width(OUT_ADDR_WIDTH);
    localparam logic [OUT_ADDR_WIDTH:0]   LAST_ADDR = (OUT_ADDR_WIDTH+1)'(N - 1);
    localparam logic [OUT_ADDR_WIDTH+1:0] N_EXT     = (OUT_ADDR_WIDTH+2)'(N);

    // Lag = 2*idx - N, worked in one extra bit then truncated to LAG_W.
    function automatic logic signed [LAG_W-1:0] calc_lag(input logic [OUT_ADDR_WIDTH-1:0] idx);
        logic [OUT_ADDR_WIDTH+1:0] t;
        t = {1'b0, idx, 1'b0} - N_EXT;
        return signed'(t[LAG_W-1:0]);
    endfunction

    peak_state_t                 state_q, state_d;
    logic [OUT_ADDR_WIDTH:0]     cnt_q;
    logic                        prev_valid;
    logic                        start;
    logic                        clear;
    logic                        vld_p1;
    logic [OUT_ADDR_WIDTH-1:0]   idx_p1;
    logic [DATA_WIDTH-1:0]       max_val;
    logic [OUT_ADDR_WIDTH-1:0]   max_idx;

    assign r_addr = cnt_q[OUT_ADDR_WIDTH-1:0];

    // Next-state, start detection and status outputs.
    always_comb begin
        state_d = state_q;
        start   = valid_in && !prev_valid;
        clear   = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    clear   = 1'b1;
                end
            end
            SCAN:    if (cnt_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, address counter, edge history, read-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_valid <= 1'b1;
            vld_p1     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_valid <= valid_in;
            vld_p1     <= (state_q == SCAN);
            if (clear)
                cnt_q <= '0;
            else if (state_q == SCAN)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // p0 -> p1: address issued this cycle pairs with RAM data next cycle.
    always_ff @(posedge clk) begin
        idx_p1 <= cnt_q[OUT_ADDR_WIDTH-1:0];
    end

    peak_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (OUT_ADDR_WIDTH)
    ) u_tracker (
        .clk        (clk),
        .clear      (clear),
        .sample_vld (vld_p1),
        .data       (r_data),
        .index      (idx_p1),
        .max_val    (max_val),
        .max_idx    (max_idx)
    );

    // Capture results as the last sample merges, so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_idx   <= '0;
            peak_val   <= '0;
            peak_lag   <= '0;
`ifdef PEAK_THRESHOLD_EN
            peak_found <= 1'b0;
`endif
        end else if (state_q == DRAIN) begin
            peak_idx   <= max_idx;
            peak_val   <= max_val;
            peak_lag   <= calc_lag(max_idx);
`ifdef PEAK_THRESHOLD_EN
            peak_found <= (max_val >= thresh);
`endif
        end
    end

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Directed bench for xcorr_peak_finder with a behavioural 1-cycle RAM and
// an expected-result queue consumed at each done pulse.
module tb_xcorr_peak_finder;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int N  = 1 << AW;

    typedef struct {
        logic [AW-1:0]        idx;
        logic [DW-1:0]        val;
        logic signed [AW:0]   lag;
        logic                 found;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  valid_in = 1'b1;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_data;
    logic                  busy, done;
    logic [AW-1:0]         peak_idx;
    logic signed [AW:0]    peak_lag;
    logic [DW-1:0]         peak_val;
    logic [DW-1:0]         thresh = 8'd150;
    logic                  peak_found;

    logic [DW-1:0]         mem [N];
    exp_t                  sb [$];
    int                    vectors = 0;
    int                    miscompares = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) r_data <= mem[r_addr];

    xcorr_peak_finder #(.DATA_WIDTH(DW), .OUT_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .r_addr     (r_addr),
        .r_data     (r_data),
`ifdef PEAK_THRESHOLD_EN
        .thresh     (thresh),
        .peak_found (peak_found),
`endif
        .busy       (busy),
        .done       (done),
        .peak_idx   (peak_idx),
        .peak_lag   (peak_lag),
        .peak_val   (peak_val)
    );
`ifndef PEAK_THRESHOLD_EN
    assign peak_found = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int k = 0; k < N; k++) mem[k] = v;
    endtask

    function automatic exp_t model();
        exp_t e;
        e.idx = '0;
        e.val = mem[0];
        for (int k = 1; k < N; k++)
            if (mem[k] > e.val) begin
                e.val = mem[k];
                e.idx = AW'(k);
            end
        e.lag   = (AW+1)'(2 * int'(e.idx) - N);
        e.found = 1'b0;
        return e;
    endfunction

    // Fresh valid_in edge, wait (bounded) for done, check timing and results.
    task automatic run_search(input string tag, input logic toggle);
        int   cyc;
        int   busy_n;
        logic seen;
        exp_t e;
        cyc = 0; busy_n = 0; seen = 1'b0;
        valid_in = 1'b0;
        tick();
        valid_in = 1'b1;
        while (cyc < 400 && !seen) begin
            tick();
            cyc++;
            if (busy) busy_n++;
            if (toggle && cyc == 50) valid_in = 1'b0;
            if (toggle && cyc == 52) valid_in = 1'b1;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, cyc, N + 2);
        check({tag, "_busy_cycles"}, busy_n, N + 2);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_peak_idx"}, peak_idx, e.idx);
            check({tag, "_peak_val"}, peak_val, e.val);
            check({tag, "_peak_lag"}, peak_lag, e.lag);
`ifdef PEAK_THRESHOLD_EN
            check({tag, "_peak_found"}, peak_found, e.found);
`endif
        end
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // Watch for any done/busy over a window where no search should run.
    task automatic quiet_window(input string tag, input int cycles);
        int d_n;
        int b_n;
        d_n = 0; b_n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) d_n++;
            if (busy) b_n++;
        end
        check({tag, "_no_done"}, d_n, 0);
        check({tag, "_no_busy"}, b_n, 0);
    endtask

    initial begin
        exp_t e;
        int   waited;
        fill('0);

        // Reset with valid_in already high; release must not trigger.
        repeat (3) tick();
        reset = 1'b0;
        check("rst_r_addr", r_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_peak_idx", peak_idx, 0);
        check("rst_peak_lag", peak_lag, 0);
        check("rst_peak_val", peak_val, 0);
        check("rst_peak_found", peak_found, 0);
        quiet_window("level_at_release", 300);

        // Ramp buffer.
        for (int k = 0; k < N; k++) mem[k] = DW'(k);
        sb.push_back('{idx: 8'd255, val: 8'd255, lag: 9'sd254, found: 1'b1});
        run_search("ramp", 1'b0);

        // Single spike, with a second valid_in edge mid-scan.
        fill(8'd10);
        mem[128] = 8'd200;
        sb.push_back('{idx: 8'd128, val: 8'd200, lag: 9'sd0, found: 1'b1});
        run_search("spike", 1'b1);
        quiet_window("spike_no_extra", 300);

        // Tie resolves to the lowest address.
        fill('0);
        mem[40] = 8'd77;
        mem[90] = 8'd77;
        sb.push_back('{idx: 8'd40, val: 8'd77, lag: -9'sd176, found: 1'b0});
        run_search("tie", 1'b0);

        // Reset at scan address 100 aborts the search.
        valid_in = 1'b0;
        tick();
        valid_in = 1'b1;
        waited = 0;
        while (waited < 300 && r_addr != 8'd100) begin
            tick();
            waited++;
        end
        check("abort_reach_addr100", r_addr, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_r_addr", r_addr, 0);
        check("abort_peak_idx", peak_idx, 0);
        check("abort_peak_val", peak_val, 0);
        check("abort_peak_lag", peak_lag, 0);
        quiet_window("abort", 300);

        // All-zero buffer.
        fill('0);
        sb.push_back('{idx: 8'd0, val: 8'd0, lag: -9'sd256, found: 1'b0});
        run_search("zero", 1'b0);

        // Maximum at the very first address.
        fill(8'd249);
        mem[0] = 8'd250;
        sb.push_back('{idx: 8'd0, val: 8'd250, lag: -9'sd256, found: 1'b1});
        run_search("addr0", 1'b0);

        // Random buffer against a reference scan.
        for (int k = 0; k < N; k++) mem[k] = DW'($urandom_range(0, 255));
        e = model();
        e.found = (e.val >= thresh);
        sb.push_back(e);
        run_search("random", 1'b0);

`ifdef PEAK_THRESHOLD_EN
        fill('0);
        mem[17] = 8'd149;
        sb.push_back('{idx: 8'd17, val: 8'd149, lag: -9'sd222, found: 1'b0});
        run_search("thr_149", 1'b0);
        mem[17] = 8'd150;
        sb.push_back('{idx: 8'd17, val: 8'd150, lag: -9'sd222, found: 1'b1});
        run_search("thr_150", 1'b0);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
